// File: rtl/triangular_pulse_gen_pkg.sv
// Shared types and constants for the triangular pulse generator.
//   state_t    : handshake/pulse FSM states
//   MODE_*     : shape select values carried on the descriptor m bit
//   DIR_*      : step direction relative to the rest level
//   mid(w)     : rest level 2^(w-1) for a w-bit offset-binary sample
package tpg_pkg;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RISE     = 3'd3,
    S_FALL     = 3'd4
  } state_t;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

  localparam logic DIR_AWAY   = 1'b0;
  localparam logic DIR_TOWARD = 1'b1;

  // Rest level of a w-bit offset-binary word.
  function automatic int unsigned mid(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/triangular_pulse_gen_if.sv
// Descriptor handshake between the producer and the pulse generator.
//   s, h, m : pulse descriptor (sign, height in LSBs, shape)
//   dav_    : data valid, active low, driven by the producer
//   rfd     : ready for data, driven by the generator
interface triangular_pulse_gen_if #(
  parameter int unsigned W = 8
) ();
  logic         s;
  logic [W-2:0] h;
  logic         m;
  logic         dav_;
  logic         rfd;

  modport master (output s, output h, output m, output dav_, input rfd);
  modport slave  (input s, input h, input m, input dav_, output rfd);
endinterface

// File: rtl/tpg_step.sv
// One-LSB step of an offset-binary sample, away from or toward the rest level.
//   val   : current sample
//   s     : pulse sign (0 above rest, 1 below rest)
//   dir   : DIR_AWAY or DIR_TOWARD
//   nxt_c : val +/- 1 (combinational)
module tpg_step
  import tpg_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] val,
  input  logic         s,
  input  logic         dir,
  output logic [W-1:0] nxt_c
);

  // Positive pulse moving away, or negative pulse moving toward, counts up.
  always_comb begin
    nxt_c = val + W'(1);
    if ((s ^ dir) == 1'b1) begin
      nxt_c = val - W'(1);
    end
  end

endmodule

// File: rtl/triangular_pulse_gen.sv
// Descriptor-driven sawtooth/triangle pulse generator feeding an offset-binary D/A.
//   clock  : system clock, rising edge
//   reset_ : asynchronous active-low reset
//   bus    : descriptor handshake (slave side)
//   out    : registered W-bit sample, rests at 2^(W-1)
module triangular_pulse_gen
  import tpg_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                   clock,
  input  logic                   reset_,
  triangular_pulse_gen_if.slave  bus,
  output logic [W-1:0]           out
);

  localparam int unsigned HW  = W - 1;
  localparam logic [W-1:0] MID = W'(mid(W));

  state_t          state_q, state_d;
  logic [HW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   h_q, h_d;
  logic            s_q, s_d;
  logic            m_q, m_d;
  logic            rfd_q, rfd_d;
  logic [W-1:0]    out_d;
  logic            dir_c;
  logic [W-1:0]    step_c;

  assign bus.rfd = rfd_q;

  // Heading back to rest once the peak is reached on a triangle, or while falling.
  assign dir_c = ((state_q == S_FALL) || ((state_q == S_RISE) && (cnt_q >= h_q)))
                 ? DIR_TOWARD : DIR_AWAY;

  tpg_step #(.W(W)) u_step (
    .val   (out),
    .s     (s_q),
    .dir   (dir_c),
    .nxt_c (step_c)
  );

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      h_q     <= '0;
      s_q     <= 1'b0;
      m_q     <= 1'b0;
      rfd_q   <= 1'b0;
      out     <= MID;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      s_q     <= s_d;
      m_q     <= m_d;
      rfd_q   <= rfd_d;
      out     <= out_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    s_d     = s_q;
    m_d     = m_q;
    rfd_d   = rfd_q;
    out_d   = out;

    case (state_q)
      S_INIT: begin
        rfd_d   = 1'b1;
        state_d = S_WAIT_REQ;
      end

      S_WAIT_REQ: begin
        if (!bus.dav_) begin
          s_d     = bus.s;
          h_d     = bus.h;
          m_d     = bus.m;
          rfd_d   = 1'b0;
          state_d = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        if (bus.dav_) begin
          if (h_q == '0) begin
            rfd_d   = 1'b1;
            state_d = S_WAIT_REQ;
          end else begin
            out_d   = step_c;
            cnt_d   = HW'(1);
            state_d = S_RISE;
          end
        end
      end

      S_RISE: begin
        if (cnt_q < h_q) begin
          out_d = step_c;
          cnt_d = cnt_q + HW'(1);
        end else if (m_q == MODE_SAW) begin
          out_d   = MID;
          rfd_d   = 1'b1;
          state_d = S_WAIT_REQ;
        end else begin
          // h=1 triangles reach rest on the turn-around step itself.
          out_d = step_c;
          if (step_c == MID) begin
            rfd_d   = 1'b1;
            state_d = S_WAIT_REQ;
          end else begin
            state_d = S_FALL;
          end
        end
      end

      S_FALL: begin
        out_d = step_c;
        if (step_c == MID) begin
          rfd_d   = 1'b1;
          state_d = S_WAIT_REQ;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_triangular_pulse_gen.sv
// Self-checking bench: W=8 and W=12 generators share one producer; every
// sample after the ack edge is compared against a sample list built from the
// pulse shape rules.
module tb_triangular_pulse_gen;

  logic        clock = 1'b0;
  logic        reset_;
  logic        s, m;
  logic [10:0] h;
  logic        dav8_, dav12_;
  logic [7:0]  out8;
  logic [11:0] out12;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  triangular_pulse_gen_if #(.W(8))  if8  ();
  triangular_pulse_gen_if #(.W(12)) if12 ();

  assign if8.s     = s;
  assign if8.h     = h[6:0];
  assign if8.m     = m;
  assign if8.dav_  = dav8_;
  assign if12.s    = s;
  assign if12.h    = h;
  assign if12.m    = m;
  assign if12.dav_ = dav12_;

  triangular_pulse_gen #(.W(8)) dut8 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (if8),
    .out    (out8)
  );

  triangular_pulse_gen #(.W(12)) dut12 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (if12),
    .out    (out12)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int out_obs(input bit sel);
    return sel ? int'(out12) : int'(out8);
  endfunction

  function automatic int rfd_obs(input bit sel);
    return sel ? int'(if12.rfd) : int'(if8.rfd);
  endfunction

  function automatic int mid_of(input bit sel);
    return sel ? 2048 : 128;
  endfunction

  task automatic set_dav(input bit sel, input logic v);
    if (sel) dav12_ = v;
    else     dav8_  = v;
  endtask

  // Sample list after the ack edge: walk out h steps, then either snap back
  // (sawtooth) or walk back down to rest (triangle).
  function automatic void pulse_model(input int md, input bit sg, input int ht,
                                      input bit mo, output int q[$]);
    int dirn;
    q = {};
    dirn = sg ? -1 : 1;
    for (int k = 1; k <= ht; k++) q.push_back(md + dirn * k);
    if (!mo) q.push_back(md);
    else for (int k = ht - 1; k >= 0; k--) q.push_back(md + dirn * k);
  endfunction

  // One full descriptor transaction with a slow producer and random
  // scrambling of the descriptor lines once they have been captured.
  task automatic run_desc(input bit sel, input bit s_i, input int h_i, input bit m_i);
    int exp_q[$];
    int cyc;
    int md;
    md = mid_of(sel);
    @(negedge clock);
    cyc = 0;
    while (rfd_obs(sel) != 1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("rfd_ready", rfd_obs(sel), 1);
    s = s_i; h = 11'(h_i); m = m_i;
    set_dav(sel, 1'b0);
    @(posedge clock); #1;
    check("rfd_capture", rfd_obs(sel), 0);
    check("out_rest_req", out_obs(sel), md);
    s = 1'($urandom); h = 11'($urandom); m = 1'($urandom);
    repeat ($urandom_range(0, 3)) begin
      @(posedge clock); #1;
      check("out_rest_wait", out_obs(sel), md);
    end
    @(negedge clock);
    set_dav(sel, 1'b1);
    pulse_model(md, s_i, h_i, m_i, exp_q);
    @(posedge clock); #1;
    if (h_i == 0) begin
      check("h0_out", out_obs(sel), md);
      check("h0_rfd", rfd_obs(sel), 1);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) begin
          @(posedge clock); #1;
          s = 1'($urandom); h = 11'($urandom); m = 1'($urandom);
        end
        check("sample", out_obs(sel), exp_q[i]);
        check("rfd_pulse", rfd_obs(sel), (i == exp_q.size() - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int cyc;
    reset_ = 1'b0;
    s = 1'b0; h = '0; m = 1'b0;
    dav8_ = 1'b0;
    dav12_ = 1'b1;

    // Reset values, then a request already pending when reset releases.
    repeat (2) @(posedge clock);
    #1;
    check("rst_out8", out8, 'h80);
    check("rst_rfd8", if8.rfd, 0);
    check("rst_out12", out12, 'h800);
    check("rst_rfd12", if12.rfd, 0);
    @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock); #1;
    check("init_rfd8", if8.rfd, 1);
    check("init_rfd12", if12.rfd, 1);
    @(posedge clock); #1;
    check("late_req_rfd", if8.rfd, 0);
    @(negedge clock);
    dav8_ = 1'b1;
    @(posedge clock); #1;
    check("late_req_h0_rfd", if8.rfd, 1);
    check("late_req_h0_out", out8, 'h80);

    // Directed W=8 shapes and extremes.
    run_desc(1'b0, 1'b0, 3, 1'b0);
    run_desc(1'b0, 1'b1, 3, 1'b1);
    run_desc(1'b0, 1'b0, 0, 1'b1);
    run_desc(1'b0, 1'b1, 0, 1'b0);
    run_desc(1'b0, 1'b0, 1, 1'b1);
    run_desc(1'b0, 1'b0, 127, 1'b1);
    run_desc(1'b0, 1'b1, 127, 1'b0);

    // Reset asserted in the middle of a triangle.
    @(negedge clock);
    s = 1'b0; h = 11'd10; m = 1'b1;
    dav8_ = 1'b0;
    @(negedge clock);
    dav8_ = 1'b1;
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
    end while (out8 != 8'h85 && cyc < 40);
    check("mid_pulse_85", out8, 'h85);
    #2 reset_ = 1'b0;
    #1;
    check("async_rst_out", out8, 'h80);
    check("async_rst_rfd", if8.rfd, 0);
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock); #1;
    check("post_rst_rfd", if8.rfd, 1);
    run_desc(1'b0, 1'b0, 10, 1'b1);

    // Random W=8 descriptors.
    for (int i = 0; i < 15; i++) begin
      run_desc(1'b0, 1'($urandom), int'($urandom_range(0, 20)), 1'($urandom));
    end

    // Full-scale W=12 triangle, then random W=12 descriptors.
    run_desc(1'b1, 1'b0, 2047, 1'b1);
    for (int i = 0; i < 30; i++) begin
      run_desc(1'b1, 1'($urandom),
               ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 40)),
               1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got no-finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

endmodule
